// File: rtl/sram_arbiter_pkg.sv
// sram_arb_pkg: shared state, port and funct3 definitions for the SRAM arbiter.
package sram_arb_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
    typedef enum logic {M0, M1} port_e;
    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;
endpackage

// File: rtl/sram_lane_align.sv
// sram_lane_align: alignment check, byte masks, store replication and load extension.
module sram_lane_align
    import sram_arb_pkg::*;
(
    input  logic [2:0]  func3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic        err_o,
    output logic [3:0]  bmask_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);
    logic [31:0] sh;
    logic        sx;
    assign sh = rdata_i >> {off_i, 3'b000};
    assign sx = ~func3_i[2];
    always_comb begin
        err_o   = !(func3_i inside {F3_B, F3_BU} ||
                    (func3_i inside {F3_H, F3_HU} && !off_i[0]) ||
                    (func3_i == F3_W && off_i == 2'b00));
        bmask_o = func3_i[1:0] == 2'b00 ? 4'b0001 << off_i :
                  func3_i[1:0] == 2'b01 ? 4'b0011 << off_i : 4'b1111;
        wdata_o = func3_i[1:0] == 2'b00 ? {4{wdata_i[7:0]}} :
                  func3_i[1:0] == 2'b01 ? {2{wdata_i[15:0]}} : wdata_i;
        rdata_o = func3_i[1:0] == 2'b00 ? {{24{sh[7] & sx}}, sh[7:0]} :
                  func3_i[1:0] == 2'b01 ? {{16{sh[15] & sx}}, sh[15:0]} : sh;
    end
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin arbiter sharing one word-wide SRAM path between fetch and LSU.
module sram_arbiter
    import sram_arb_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_m0_req,
    input  logic [17:0] i_m0_addr,
    output logic [31:0] o_m0_rdata,
    output logic        o_m0_ack,
    input  logic        i_m1_rden,
    input  logic        i_m1_wren,
    input  logic [2:0]  i_m1_func3,
    input  logic [17:0] i_m1_addr,
    input  logic [31:0] i_m1_wdata,
    output logic [31:0] o_m1_rdata,
    output logic        o_m1_ack,
    output logic        o_m1_err,
    output logic [17:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_bmask,
    output logic        o_mem_wren,
    output logic        o_mem_rden,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_ack
);
    state_e      state_q, state_d;
    port_e       last_q, last_d, port_q, port_d;
    logic        wr_q, wr_d, err_q, err_d;
    logic [17:0] addr_q, addr_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic        idle, busy, resp, m1_req, al_err;
    logic [3:0]  al_bmask;
    logic [31:0] al_wdata, al_rdata;
    assign idle   = state_q == IDLE;
    assign busy   = state_q == BUSY;
    assign resp   = state_q == RESP;
    assign m1_req = i_m1_rden | i_m1_wren;
    // In IDLE the aligner validates the raw LSU request; afterwards it works on latched values.
    sram_lane_align u_align (
        .func3_i (idle ? i_m1_func3 : f3_q),
        .off_i   (idle ? i_m1_addr[1:0] : addr_q[1:0]),
        .wdata_i (wdata_q),
        .rdata_i (rdata_q),
        .err_o   (al_err),
        .bmask_o (al_bmask),
        .wdata_o (al_wdata),
        .rdata_o (al_rdata)
    );
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            last_q  <= M0;
            port_q  <= M0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            f3_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            port_q  <= port_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        port_d  = port_q;
        wr_d    = wr_q;
        err_d   = err_q;
        addr_d  = addr_q;
        f3_d    = f3_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (m1_req && (!i_m0_req || last_q == M0)) begin
                    state_d = al_err ? RESP : BUSY;
                    last_d  = M1;
                    port_d  = M1;
                    wr_d    = i_m1_wren;
                    err_d   = al_err;
                    addr_d  = i_m1_addr;
                    f3_d    = i_m1_func3;
                    wdata_d = i_m1_wdata;
                end else if (i_m0_req) begin
                    state_d = BUSY;
                    last_d  = M0;
                    port_d  = M0;
                    wr_d    = 1'b0;
                    err_d   = 1'b0;
                    addr_d  = i_m0_addr;
                    f3_d    = F3_W;
                end
            end
            BUSY: begin
                if (i_mem_ack) begin
                    rdata_d = i_mem_rdata;
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    assign o_mem_addr  = busy ? {addr_q[17:2], 2'b00} : '0;
    assign o_mem_bmask = busy ? al_bmask : '0;
    assign o_mem_wdata = busy && wr_q ? al_wdata : '0;
    assign o_mem_wren  = busy && wr_q;
    assign o_mem_rden  = busy && !wr_q;
    assign o_m0_ack    = resp && port_q == M0;
    assign o_m0_rdata  = o_m0_ack ? rdata_q : '0;
    assign o_m1_ack    = resp && port_q == M1;
    assign o_m1_err    = o_m1_ack && err_q;
    assign o_m1_rdata  = o_m1_ack && !wr_q && !err_q ? al_rdata : '0;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed self-checking bench for the SRAM arbiter.
module tb_sram_arbiter;
    import sram_arb_pkg::*;
    logic        clk = 1'b0;
    logic        rst, m0_req, m1_rden, m1_wren, mem_ack;
    logic [17:0] m0_addr, m1_addr;
    logic [2:0]  f3;
    logic [31:0] m1_wdata, mem_rdata;
    logic [31:0] o_m0_rdata, o_m1_rdata, o_mem_wdata;
    logic        o_m0_ack, o_m1_ack, o_m1_err, o_mem_wren, o_mem_rden;
    logic [17:0] o_mem_addr;
    logic [3:0]  o_mem_bmask;
    int vecs = 0;
    int miscompares = 0;
    always #5 clk = ~clk;
    sram_arbiter dut (
        .i_clk(clk), .i_reset(rst),
        .i_m0_req(m0_req), .i_m0_addr(m0_addr), .o_m0_rdata(o_m0_rdata), .o_m0_ack(o_m0_ack),
        .i_m1_rden(m1_rden), .i_m1_wren(m1_wren), .i_m1_func3(f3), .i_m1_addr(m1_addr),
        .i_m1_wdata(m1_wdata), .o_m1_rdata(o_m1_rdata), .o_m1_ack(o_m1_ack), .o_m1_err(o_m1_err),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_bmask(o_mem_bmask),
        .o_mem_wren(o_mem_wren), .o_mem_rden(o_mem_rden),
        .i_mem_rdata(mem_rdata), .i_mem_ack(mem_ack)
    );
    task tick;
        @(posedge clk);
        #1;
    endtask
    task test_reset;
        rst = 1; m0_req = 0; m1_rden = 0; m1_wren = 0; mem_ack = 0;
        m0_addr = '0; m1_addr = '0; f3 = '0; m1_wdata = '0; mem_rdata = '0;
        tick; tick;
        vecs++; if ({o_mem_wren, o_mem_rden, o_m0_ack, o_m1_ack, o_m1_err} !== 5'b0) begin miscompares++; $display("FAIL reset_strobes got %b want 00000", {o_mem_wren, o_mem_rden, o_m0_ack, o_m1_ack, o_m1_err}); end
        vecs++; if ({o_mem_addr, o_mem_bmask, o_mem_wdata} !== 54'b0) begin miscompares++; $display("FAIL reset_mem got %h want 0", {o_mem_addr, o_mem_bmask, o_mem_wdata}); end
        vecs++; if ({o_m0_rdata, o_m1_rdata} !== 64'b0) begin miscompares++; $display("FAIL reset_rdata got %h want 0", {o_m0_rdata, o_m1_rdata}); end
        vecs++; if (dut.state_q !== IDLE) begin miscompares++; $display("FAIL reset_state got %0d want IDLE", dut.state_q); end
        rst = 0;
        tick;
    endtask
    task test_store(input logic [2:0] fn, input logic [17:0] a, input logic [31:0] wd,
                    input logic [17:0] ea, input logic [3:0] em, input logic [31:0] ew);
        m1_wren = 1; f3 = fn; m1_addr = a; m1_wdata = wd;
        tick;
        vecs++; if ({o_mem_wren, o_mem_rden} !== 2'b10) begin miscompares++; $display("FAIL store_strobe a=%h got %b want 10", a, {o_mem_wren, o_mem_rden}); end
        vecs++; if (o_mem_addr !== ea) begin miscompares++; $display("FAIL store_addr a=%h got %h want %h", a, o_mem_addr, ea); end
        vecs++; if (o_mem_bmask !== em) begin miscompares++; $display("FAIL store_bmask a=%h got %b want %b", a, o_mem_bmask, em); end
        vecs++; if (o_mem_wdata !== ew) begin miscompares++; $display("FAIL store_wdata a=%h got %h want %h", a, o_mem_wdata, ew); end
        tick;
        vecs++; if ({o_mem_wren, o_mem_bmask, o_mem_wdata, o_m1_ack} !== {1'b1, em, ew, 1'b0}) begin miscompares++; $display("FAIL store_hold a=%h got %h want %h", a, {o_mem_wren, o_mem_bmask, o_mem_wdata, o_m1_ack}, {1'b1, em, ew, 1'b0}); end
        mem_ack = 1; mem_rdata = 32'hDEADBEEF;
        tick;
        mem_ack = 0; m1_wren = 0;
        vecs++; if ({o_m1_ack, o_m1_err, o_mem_wren} !== 3'b100) begin miscompares++; $display("FAIL store_ack a=%h got %b want 100", a, {o_m1_ack, o_m1_err, o_mem_wren}); end
        vecs++; if (o_m1_rdata !== 32'h0) begin miscompares++; $display("FAIL store_rdata a=%h got %h want 0", a, o_m1_rdata); end
        tick;
        vecs++; if (o_m1_ack !== 1'b0) begin miscompares++; $display("FAIL store_ack_pulse a=%h got %b want 0", a, o_m1_ack); end
    endtask
    task test_load(input logic [2:0] fn, input logic [17:0] a, input logic [3:0] em,
                   input logic [31:0] mw, input logic [31:0] er);
        m1_rden = 1; f3 = fn; m1_addr = a;
        tick;
        vecs++; if ({o_mem_wren, o_mem_rden, o_mem_bmask} !== {2'b01, em}) begin miscompares++; $display("FAIL load_req f3=%0d a=%h got %b want %b", fn, a, {o_mem_wren, o_mem_rden, o_mem_bmask}, {2'b01, em}); end
        mem_ack = 1; mem_rdata = mw;
        tick;
        mem_ack = 0; m1_rden = 0;
        vecs++; if ({o_m1_ack, o_m1_err} !== 2'b10) begin miscompares++; $display("FAIL load_ack f3=%0d a=%h got %b want 10", fn, a, {o_m1_ack, o_m1_err}); end
        vecs++; if (o_m1_rdata !== er) begin miscompares++; $display("FAIL load_rdata f3=%0d a=%h got %h want %h", fn, a, o_m1_rdata, er); end
        tick;
        vecs++; if ({o_m1_ack, o_m1_rdata} !== 33'b0) begin miscompares++; $display("FAIL load_after f3=%0d a=%h got %h want 0", fn, a, {o_m1_ack, o_m1_rdata}); end
    endtask
    task test_misaligned(input logic [2:0] fn, input logic [17:0] a, input logic wr);
        m1_rden = !wr; m1_wren = wr; f3 = fn; m1_addr = a; m1_wdata = 32'h12345678;
        tick;
        vecs++; if ({o_m1_ack, o_m1_err, o_mem_wren, o_mem_rden} !== 4'b1100) begin miscompares++; $display("FAIL misalign_resp f3=%0d a=%h got %b want 1100", fn, a, {o_m1_ack, o_m1_err, o_mem_wren, o_mem_rden}); end
        m1_rden = 0; m1_wren = 0;
        tick;
        vecs++; if ({o_m1_ack, o_m1_err, o_mem_wren, o_mem_rden} !== 4'b0000) begin miscompares++; $display("FAIL misalign_after f3=%0d a=%h got %b want 0000", fn, a, {o_m1_ack, o_m1_err, o_mem_wren, o_mem_rden}); end
    endtask
    task test_contention;
        int order [3];
        int n, a0, a1;
        bit rearm;
        n = 0; a0 = 0; a1 = 0; rearm = 0; order = '{9, 9, 9};
        m0_req = 1; m0_addr = 18'h00040; m1_rden = 1; f3 = F3_W; m1_addr = 18'h00080;
        rst = 1;
        tick;
        rst = 0;
        for (int c = 0; c < 60; c++) begin
            tick;
            if (rearm) begin m1_rden = 1; rearm = 0; end
            if (mem_ack) mem_ack = 0;
            else if (o_mem_rden) begin
                mem_ack = 1;
                mem_rdata = (o_mem_addr == 18'h00040) ? 32'h11111111 : 32'h22222222;
            end
            if (o_m0_ack) begin
                if (n < 3) order[n] = 0;
                n++; a0++; m0_req = 0;
                vecs++; if (o_m0_rdata !== 32'h11111111) begin miscompares++; $display("FAIL cont_m0_rdata got %h want 11111111", o_m0_rdata); end
            end
            if (o_m1_ack) begin
                if (n < 3) order[n] = 1;
                n++; a1++; m1_rden = 0;
                if (a1 == 1) rearm = 1;
                vecs++; if (o_m1_rdata !== 32'h22222222) begin miscompares++; $display("FAIL cont_m1_rdata got %h want 22222222", o_m1_rdata); end
            end
        end
        vecs++; if (n != 3) begin miscompares++; $display("FAIL cont_grants got %0d want 3", n); end
        vecs++; if (order[0] != 1 || order[1] != 0 || order[2] != 1) begin miscompares++; $display("FAIL cont_order got %0d,%0d,%0d want 1,0,1", order[0], order[1], order[2]); end
        vecs++; if (a0 != 1 || a1 != 2) begin miscompares++; $display("FAIL cont_acks got m0=%0d m1=%0d want m0=1 m1=2", a0, a1); end
    endtask
    task test_reset_busy;
        int acks;
        acks = 0;
        m0_req = 1; m0_addr = 18'h00300;
        tick;
        vecs++; if ({o_mem_rden, o_mem_addr} !== {1'b1, 18'h00300}) begin miscompares++; $display("FAIL rb_grant got %h want %h", {o_mem_rden, o_mem_addr}, {1'b1, 18'h00300}); end
        rst = 1;
        tick;
        vecs++; if ({o_mem_wren, o_mem_rden, o_m0_ack, o_m1_ack, o_m1_err} !== 5'b0) begin miscompares++; $display("FAIL rb_strobes got %b want 00000", {o_mem_wren, o_mem_rden, o_m0_ack, o_m1_ack, o_m1_err}); end
        vecs++; if ({o_mem_addr, o_mem_bmask, o_mem_wdata} !== 54'b0) begin miscompares++; $display("FAIL rb_mem got %h want 0", {o_mem_addr, o_mem_bmask, o_mem_wdata}); end
        vecs++; if (dut.state_q !== IDLE) begin miscompares++; $display("FAIL rb_state got %0d want IDLE", dut.state_q); end
        rst = 0;
        tick;
        vecs++; if ({o_mem_rden, o_mem_addr, o_mem_bmask} !== {1'b1, 18'h00300, 4'hF}) begin miscompares++; $display("FAIL rb_regrant got %h want %h", {o_mem_rden, o_mem_addr, o_mem_bmask}, {1'b1, 18'h00300, 4'hF}); end
        for (int c = 0; c < 10; c++) begin
            if (mem_ack) mem_ack = 0;
            else if (o_mem_rden) begin mem_ack = 1; mem_rdata = 32'h33333333; end
            tick;
            if (o_m0_ack) begin
                acks++; m0_req = 0;
                vecs++; if (o_m0_rdata !== 32'h33333333) begin miscompares++; $display("FAIL rb_rdata got %h want 33333333", o_m0_rdata); end
            end
        end
        vecs++; if (acks != 1) begin miscompares++; $display("FAIL rb_ack_count got %0d want 1", acks); end
        mem_ack = 1;
        tick;
        mem_ack = 0;
        tick;
        vecs++; if ({o_m0_ack, o_m1_ack, o_mem_rden, o_mem_wren} !== 4'b0 || dut.state_q !== IDLE) begin miscompares++; $display("FAIL idle_mem_ack got %b/%0d want 0000/IDLE", {o_m0_ack, o_m1_ack, o_mem_rden, o_mem_wren}, dut.state_q); end
    endtask
    initial begin
        test_reset;
        test_store(F3_B, 18'h00103, 32'h000000A5, 18'h00100, 4'b1000, 32'hA5A5A5A5);
        test_store(F3_H, 18'h00202, 32'hCAFE1234, 18'h00200, 4'b1100, 32'h12341234);
        test_store(F3_W, 18'h00004, 32'h01234567, 18'h00004, 4'b1111, 32'h01234567);
        test_load(F3_H,  18'h00202, 4'b1100, 32'h80FF1234, 32'hFFFF80FF);
        test_load(F3_HU, 18'h00202, 4'b1100, 32'h80FF1234, 32'h000080FF);
        test_load(F3_B,  18'h00001, 4'b0010, 32'h00008000, 32'hFFFFFF80);
        test_load(F3_BU, 18'h00003, 4'b1000, 32'h7F000000, 32'h0000007F);
        test_load(F3_W,  18'h00008, 4'b1111, 32'h89ABCDEF, 32'h89ABCDEF);
        test_misaligned(F3_W, 18'h00006, 1'b0);
        test_misaligned(3'd3, 18'h00004, 1'b0);
        test_misaligned(F3_H, 18'h00101, 1'b1);
        test_misaligned(3'd7, 18'h00000, 1'b1);
        test_contention;
        test_reset_busy;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end
endmodule
